// File: rtl/tri_st_cntz_ex_pkg.sv
// Shared definitions for the count-zeros execution unit: widths, CR0 bit
// positions, the stage control record and the operand bit-reverse helper.
package tri_st_cntz_ex_pkg;

    localparam int GPR_W  = 64;
    localparam int CNT_W  = 7;
    localparam int ITAG_W = 7;

    // CR0 field positions, big-endian numbering (bit 0 = LT)
    localparam int CR_LT = 0;
    localparam int CR_GT = 1;
    localparam int CR_EQ = 2;
    localparam int CR_SO = 3;

    // Control carried alongside the operand through each stage register
    typedef struct packed {
        logic              vld;
        logic [ITAG_W-1:0] itag;
        logic              rc;
        logic              so;
    } ex_ctl_t;

    // Mirror a 64-bit value end for end (bit i <- bit 63-i)
    function automatic logic [0:GPR_W-1] bit_rev(input logic [0:GPR_W-1] d);
        logic [0:GPR_W-1] r;
        for (int i = 0; i < GPR_W; i++) begin
            r[i] = d[GPR_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/tri_st_cntz_ex_cntlz.sv
// Combinational 64-bit leading-zero counter (tri_st_cntlz). In word mode only
// bits 32:63 are considered and the result spans 0..32; in doubleword mode the
// result spans 0..64.
module tri_st_cntlz
    import tri_st_cntz_ex_pkg::*;
(
    input  logic [0:GPR_W-1] a,
    input  logic             dword,
    output logic [0:CNT_W-1] y
);

    logic [0:GPR_W-1] masked;
    logic [CNT_W-1:0] lz;

    // Position of the first set bit from the MSB end; all-zero yields 64
    always_comb begin
        masked = a;
        if (!dword) begin
            masked[0:31] = '0;
        end
        lz = CNT_W'(GPR_W);
        for (int i = GPR_W - 1; i >= 0; i--) begin
            if (masked[i]) begin
                lz = CNT_W'(i);
            end
        end
        // A word count starts at bit 32, so its leading zeros exclude the upper half
        y = dword ? lz : lz - CNT_W'(32);
    end

endmodule

// File: rtl/tri_st_cntz_ex.sv
// Two-stage count-zeros unit (cntlzw/cntlzd/cnttzw/cnttzd, with Rc forms).
// EX1 formats the operand so the EX2 counter only ever counts leading zeros;
// EX2 counts and builds CR0; results are presented from the EX3 register.
module tri_st_cntz_ex
    import tri_st_cntz_ex_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ex1_vld,
    input  logic [0:ITAG_W-1] ex1_itag,
    input  logic              ex1_dword,
    input  logic              ex1_tz,
    input  logic              ex1_rc,
    input  logic              ex1_xer_so,
    input  logic [0:GPR_W-1]  ex1_rs,
    input  logic              ex_stall,
    input  logic              ex_flush,
    output logic              ex3_vld,
    output logic [0:ITAG_W-1] ex3_itag,
    output logic [0:GPR_W-1]  ex3_rt,
    output logic              ex3_cr_vld,
    output logic [0:3]        ex3_cr
);

    logic             stage_en;
    logic [0:GPR_W-1] ex1_op;

    ex_ctl_t          ex2_ctl;
    logic             ex2_dword;
    logic [0:GPR_W-1] ex2_op;
    logic [0:CNT_W-1] ex2_cnt;
    logic [0:3]       ex2_cr;

    // Flush and reset must always be able to clear the stages, even under stall
    assign stage_en = ~ex_stall | ex_flush | rst;

    // EX1: turn a trailing-zero count into a leading-zero count by reversal;
    // the word form reverses only the low word so it lands back in bits 32:63
    always_comb begin
        ex1_op = ex1_rs;
        if (ex1_tz) begin
            ex1_op = ex1_dword ? bit_rev(ex1_rs) : bit_rev({ex1_rs[32:63], 32'b0});
        end
        if (!ex1_dword) begin
            ex1_op[0:31] = '0;
        end
    end

    // ---- EX1 / EX2 boundary ----
    // EX2 control: valid is cleared by reset and flush, held by stall
    always_ff @(posedge clk) begin
        if (rst) begin
            ex2_ctl.vld <= 1'b0;
        end else if (stage_en) begin
            ex2_ctl.vld <= ex1_vld & ~ex_flush;
        end
    end

    // EX2 payload: no reset needed, qualified by ex2 valid downstream
    always_ff @(posedge clk) begin
        if (stage_en) begin
            ex2_ctl.itag <= ex1_itag;
            ex2_ctl.rc   <= ex1_rc;
            ex2_ctl.so   <= ex1_xer_so;
            ex2_dword    <= ex1_dword;
            ex2_op       <= ex1_op;
        end
    end

    tri_st_cntlz u_cntlz (
        .a     (ex2_op),
        .dword (ex2_dword),
        .y     (ex2_cnt)
    );

    // EX2: CR0 from the count; a count can never be negative so LT stays clear
    always_comb begin
        ex2_cr        = '0;
        ex2_cr[CR_LT] = 1'b0;
        ex2_cr[CR_GT] = |ex2_cnt;
        ex2_cr[CR_EQ] = ~|ex2_cnt;
        ex2_cr[CR_SO] = ex2_ctl.so;
    end

    // ---- EX2 / EX3 boundary ----
    // EX3 result register; outputs are driven straight from these flops
    always_ff @(posedge clk) begin
        if (rst) begin
            ex3_vld    <= 1'b0;
            ex3_cr_vld <= 1'b0;
            ex3_itag   <= '0;
            ex3_rt     <= '0;
            ex3_cr     <= '0;
        end else if (stage_en) begin
            ex3_vld    <= ex2_ctl.vld & ~ex_flush;
            ex3_cr_vld <= ex2_ctl.vld & ex2_ctl.rc & ~ex_flush;
            ex3_itag   <= ex2_ctl.itag;
            ex3_rt     <= {{(GPR_W-CNT_W){1'b0}}, ex2_cnt};
            ex3_cr     <= ex2_cr;
        end
    end

endmodule
